// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding, header size,
// checksum width and the state decode that tells whether a state takes stream bytes.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    INSTR,
    CLEAR,
    DATA,
    CKSUM,
    RUN,
    ERROR
  } boot_state_e;

  localparam int HDR_BYTES = 2;
  localparam int CKSUM_W   = 8;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic boot_accepts(input boot_state_e s);
    logic v;
    case (s)
      HDR0, HDR1, INSTR, DATA, CKSUM: v = 1'b1;
      default:                        v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Four-byte little-endian word assembler: bytes shift in from the top, the word is
// presented combinationally together with a done pulse when the fourth byte arrives.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  r_lane;
  logic [23:0] r_low;

  assign word_done_o = byte_valid_i && (r_lane == 2'd3);
  assign word_o      = {byte_i, r_low};

  // Lane counter and lower three bytes; a right shift leaves byte 0 in bits 7:0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lane <= 2'd0;
      r_low  <= 24'h000000;
    end else if (clr_i) begin
      r_lane <= 2'd0;
    end else if (byte_valid_i) begin
      r_lane <= r_lane + 2'd1;
      r_low  <= {byte_i, r_low[23:8]};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: takes a framed byte stream, fills instruction/data memory, zeroes the unused
// instruction words and then releases the CPU. Trailing checksum byte enabled by BOOT_CHECKSUM_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int IMEM_AW    = 8,
  parameter int DMEM_AW    = 5,
  parameter int DATA_BYTES = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  output logic               start_o,
  output logic               err_o
);

  localparam logic [IMEM_AW:0]   W_ONE   = (IMEM_AW+1)'(1);
  localparam logic [IMEM_AW:0]   W_DEPTH = (IMEM_AW+1)'(IMEM_DEPTH);
  localparam logic [IMEM_AW:0]   W_LAST  = (IMEM_AW+1)'(IMEM_DEPTH - 1);
  localparam logic [15:0]        HDR_MAX = 16'(IMEM_DEPTH);
  localparam logic [DMEM_AW-1:0] D_ONE   = DMEM_AW'(1);
  localparam logic [DMEM_AW-1:0] D_LAST  = DMEM_AW'(DATA_BYTES - 1);

  boot_state_e        r_state, w_next_state;
  logic               r_ready, w_acc;
  logic [7:0]         r_n_lo;
  logic [15:0]        w_hdr_n;
  logic               w_hdr_bad;
  logic [IMEM_AW:0]   r_n, r_widx;
  logic [DMEM_AW-1:0] r_didx;
  logic               w_asm_valid, w_asm_clr, w_word_done, w_last_word;
  logic [31:0]        w_word, w_imem_data;
  logic               w_imem_we, w_dmem_we;
  logic               r_imem_we, r_dmem_we, r_start, r_err;
  logic [IMEM_AW-1:0] r_imem_addr;
  logic [31:0]        r_imem_data;
  logic [DMEM_AW-1:0] r_dmem_addr;
  logic [7:0]         r_dmem_data;
`ifdef BOOT_CHECKSUM_EN
  logic [CKSUM_W-1:0] r_csum;
`endif

  assign w_acc       = byte_valid_i && r_ready;
  // Count is judged at full 16 bits so e.g. 0x0201 cannot alias to a legal value.
  assign w_hdr_n     = {byte_i, r_n_lo};
  assign w_hdr_bad   = (w_hdr_n == 16'd0) || (w_hdr_n > HDR_MAX);
  assign w_asm_valid = w_acc && (r_state == INSTR);
  assign w_asm_clr   = (r_state != INSTR);
  assign w_last_word = w_word_done && (r_widx == (r_n - W_ONE));

  boot_word_asm u_word_asm (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clr_i        (w_asm_clr),
    .byte_valid_i (w_asm_valid),
    .byte_i       (byte_i),
    .word_o       (w_word),
    .word_done_o  (w_word_done)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= HDR0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and the write strobes that get registered below.
  always_comb begin
    w_next_state = r_state;
    w_imem_we    = 1'b0;
    w_imem_data  = 32'h00000000;
    w_dmem_we    = 1'b0;
    case (r_state)
      HDR0: begin
        if (w_acc) w_next_state = HDR1;
        else       w_next_state = r_state;
      end
      HDR1: begin
        if (w_acc) begin
          if (w_hdr_bad) w_next_state = ERROR;
          else           w_next_state = INSTR;
        end else begin
          w_next_state = r_state;
        end
      end
      INSTR: begin
        w_imem_we   = w_word_done;
        w_imem_data = w_word;
        if (w_last_word) begin
          if (r_n == W_DEPTH) w_next_state = DATA;
          else                w_next_state = CLEAR;
        end else begin
          w_next_state = r_state;
        end
      end
      CLEAR: begin
        w_imem_we = 1'b1;
        if (r_widx == W_LAST) w_next_state = DATA;
        else                  w_next_state = r_state;
      end
      DATA: begin
        w_dmem_we = w_acc;
        if (w_acc && (r_didx == D_LAST)) begin
`ifdef BOOT_CHECKSUM_EN
          w_next_state = CKSUM;
`else
          w_next_state = RUN;
`endif
        end else begin
          w_next_state = r_state;
        end
      end
      CKSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (w_acc) begin
          if (byte_i == r_csum) w_next_state = RUN;
          else                  w_next_state = ERROR;
        end else begin
          w_next_state = r_state;
        end
`else
        w_next_state = ERROR;
`endif
      end
      RUN:     w_next_state = RUN;
      ERROR:   w_next_state = ERROR;
      default: w_next_state = ERROR;
    endcase
  end

  // Header capture plus word and data byte counters; the word counter also walks CLEAR.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_n_lo <= 8'h00;
      r_n    <= {(IMEM_AW+1){1'b0}};
      r_widx <= {(IMEM_AW+1){1'b0}};
      r_didx <= {DMEM_AW{1'b0}};
    end else begin
      if ((r_state == HDR0) && w_acc) r_n_lo <= byte_i;
      if ((r_state == HDR1) && w_acc) begin
        r_n    <= w_hdr_n[IMEM_AW:0];
        r_widx <= {(IMEM_AW+1){1'b0}};
        r_didx <= {DMEM_AW{1'b0}};
      end else begin
        if (w_imem_we) r_widx <= r_widx + W_ONE;
        if (w_dmem_we) r_didx <= r_didx + D_ONE;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // XOR of every payload byte; header bytes are left out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_csum <= {CKSUM_W{1'b0}};
    end else if (r_state == HDR1) begin
      r_csum <= {CKSUM_W{1'b0}};
    end else if (w_acc && ((r_state == INSTR) || (r_state == DATA))) begin
      r_csum <= r_csum ^ byte_i;
    end
  end
`endif

  // Registered outputs; address/data only move together with their strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ready     <= 1'b0;
      r_imem_we   <= 1'b0;
      r_imem_addr <= {IMEM_AW{1'b0}};
      r_imem_data <= 32'h00000000;
      r_dmem_we   <= 1'b0;
      r_dmem_addr <= {DMEM_AW{1'b0}};
      r_dmem_data <= 8'h00;
      r_start     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ready   <= boot_accepts(w_next_state);
      r_imem_we <= w_imem_we;
      if (w_imem_we) begin
        r_imem_addr <= r_widx[IMEM_AW-1:0];
        r_imem_data <= w_imem_data;
      end
      r_dmem_we <= w_dmem_we;
      if (w_dmem_we) begin
        r_dmem_addr <= r_didx;
        r_dmem_data <= byte_i;
      end
      r_start <= (r_state == RUN);
      r_err   <= (w_next_state == ERROR);
    end
  end

  assign byte_ready_o = r_ready;
  assign imem_we_o    = r_imem_we;
  assign imem_addr_o  = r_imem_addr;
  assign imem_data_o  = r_imem_data;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_data_o  = r_dmem_data;
  assign start_o      = r_start;
  assign err_o        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: frames are built as byte queues, the expected memory
// write sequence is derived from the frame, and a negedge monitor checks every strobe against it.
module tb_boot_loader;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;
  localparam int DMEM_AW    = 5;
  localparam int DATA_BYTES = 4;

  typedef struct { int addr; logic [31:0] data; bit clr; } iw_t;
  typedef struct { int addr; logic [7:0] data; } dw_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_valid = 1'b0;
  logic               byte_ready_o;
  logic               imem_we_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_data_o;
  logic               dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [7:0]         dmem_data_o;
  logic               start_o;
  logic               err_o;

  boot_loader #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_AW    (IMEM_AW),
    .DMEM_AW    (DMEM_AW),
    .DATA_BYTES (DATA_BYTES)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .byte_i       (byte_in),
    .byte_valid_i (byte_valid),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_data_o  (dmem_data_o),
    .start_o      (start_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame under test and the model of what it must do to the memories.
  logic [31:0] f_words [IMEM_DEPTH];
  logic [7:0]  f_data  [DATA_BYTES];
  logic [7:0]  frame_q [$];
  iw_t         exp_iq  [$];
  dw_t         exp_dq  [$];
  logic [7:0]  cksum_val;
  bit          exp_err;
  bit          aborted;
  int          data_last_idx;

  // Observations.
  logic [31:0] shadow_imem [IMEM_DEPTH];
  logic [7:0]  shadow_dmem [32];
  int          n_clear, prev_imem_cyc, last_imem_addr, last_dmem_cyc;
  int          last_acc_cyc, data_acc_cyc;
  bit          seen_imem;
  logic        prev_start = 1'b0;
  iw_t         mon_iw;
  dw_t         mon_dw;

  int bad_n [3] = '{0, 257, 513};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must be the next expected write; start/err must be consistent.
  always @(negedge clk) begin
    if (imem_we_o) begin
      if (exp_iq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL imem_unexpected: write addr %0d data %h with none pending", imem_addr_o, imem_data_o);
      end else begin
        mon_iw = exp_iq.pop_front();
        chk("imem_addr", 32'(imem_addr_o), mon_iw.addr);
        chk("imem_data", imem_data_o, mon_iw.data);
        if (mon_iw.clr) begin
          n_clear++;
          if (seen_imem) chk("clear_back_to_back", cyc - prev_imem_cyc, 1);
        end
      end
      shadow_imem[imem_addr_o] = imem_data_o;
      prev_imem_cyc  = cyc;
      last_imem_addr = 32'(imem_addr_o);
      seen_imem      = 1'b1;
    end
    if (dmem_we_o) begin
      if (exp_dq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dmem_unexpected: write addr %0d data %h with none pending", dmem_addr_o, dmem_data_o);
      end else begin
        mon_dw = exp_dq.pop_front();
        chk("dmem_addr", 32'(dmem_addr_o), mon_dw.addr);
        chk("dmem_data", 32'(dmem_data_o), 32'(mon_dw.data));
      end
      shadow_dmem[dmem_addr_o] = dmem_data_o;
      last_dmem_cyc = cyc;
    end
    if (start_o) chk("start_early", exp_iq.size() + exp_dq.size(), 0);
    if (start_o && !prev_start) chk("start_timing", cyc, last_acc_cyc + 1);
    if (err_o) chk("err_allowed", 32'(exp_err), 1);
    prev_start = start_o;
  end

  task automatic build_frame(input int n, input bit bad_ck);
    logic [7:0] x;
    logic [7:0] b;
    iw_t iw;
    dw_t dw;
    frame_q.delete();
    exp_iq.delete();
    exp_dq.delete();
    x = 8'h00;
    frame_q.push_back(8'(n & 255));
    frame_q.push_back(8'((n >> 8) & 255));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(f_words[w] >> (8 * k));
        frame_q.push_back(b);
        x = x ^ b;
      end
    end
    for (int j = 0; j < DATA_BYTES; j++) begin
      frame_q.push_back(f_data[j]);
      x = x ^ f_data[j];
    end
`ifdef BOOT_CHECKSUM_EN
    frame_q.push_back(bad_ck ? (x ^ 8'h01) : x);
`endif
    cksum_val = x;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      iw.addr = i;
      iw.data = (i < n) ? f_words[i] : 32'h0;
      iw.clr  = (i >= n);
      exp_iq.push_back(iw);
    end
    for (int j = 0; j < DATA_BYTES; j++) begin
      dw.addr = j;
      dw.data = f_data[j];
      exp_dq.push_back(dw);
    end
    n_clear       = 0;
    seen_imem     = 1'b0;
    exp_err       = bad_ck;
    data_last_idx = 2 + 4 * n + DATA_BYTES - 1;
  endtask

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int mode);
    int gap;
    int t;
    gap = 0;
    if (mode == 1) begin
      gap = 1;
      if ($urandom_range(0, 3) == 0) gap = 3;
    end else if (mode == 2) begin
      gap = $urandom_range(0, 2);
    end
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte %h not accepted within 2000 cycles", b);
      aborted = 1'b1;
    end else begin
      @(negedge clk);
      last_acc_cyc = cyc;
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input int limit);
    int cnt;
    aborted = 1'b0;
    cnt = (limit < 0 || limit > frame_q.size()) ? frame_q.size() : limit;
    for (int i = 0; i < cnt && !aborted; i++) begin
      send_byte(frame_q[i], mode);
      if (i == data_last_idx) data_acc_cyc = last_acc_cyc;
    end
  endtask

  task automatic finish_frame(input bit ok);
    @(negedge clk);
    @(negedge clk);
    chk("imem_writes_done", exp_iq.size(), 0);
    chk("dmem_writes_done", exp_dq.size(), 0);
    chk("start_level", 32'(start_o), 32'(ok));
    chk("err_level", 32'(err_o), 32'(!ok));
    chk("ready_after_load", 32'(byte_ready_o), 0);
    chk("dmem_latency", last_dmem_cyc, data_acc_cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_start_async", 32'(start_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ready", 32'(byte_ready_o), 0);
    exp_iq.delete();
    exp_dq.delete();
    exp_err    = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(byte_ready_o), 1);
  endtask

  task automatic poison_shadow();
    for (int i = 0; i < IMEM_DEPTH; i++) shadow_imem[i] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) shadow_dmem[i] = 8'hA5;
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(byte_ready_o), 0);
    chk("reset_imem_we", 32'(imem_we_o), 0);
    chk("reset_imem_addr", 32'(imem_addr_o), 0);
    chk("reset_imem_data", imem_data_o, 0);
    chk("reset_dmem_we", 32'(dmem_we_o), 0);
    chk("reset_dmem_data", 32'(dmem_data_o), 0);
    chk("reset_start", 32'(start_o), 0);
    chk("reset_err", 32'(err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_hdr0", 32'(byte_ready_o), 1);

    // Directed N=2 frame, continuous valid, then the same frame with toggling valid and gaps.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) do_reset();
      f_words[0] = 32'h20080005;
      f_words[1] = 32'h01094020;
      f_data[0] = 8'h05; f_data[1] = 8'h00; f_data[2] = 8'h00; f_data[3] = 8'h00;
      poison_shadow();
      build_frame(2, 1'b0);
      run_frame(pass, -1);
      finish_frame(1'b1);
      chk("img_imem0", shadow_imem[0], 32'h20080005);
      chk("img_imem1", shadow_imem[1], 32'h01094020);
      chk("img_imem2", shadow_imem[2], 32'h00000000);
      chk("img_imem255", shadow_imem[255], 32'h00000000);
      chk("img_dmem0", 32'(shadow_dmem[0]), 32'h05);
      chk("img_dmem1", 32'(shadow_dmem[1]), 32'h00);
      chk("img_dmem3", 32'(shadow_dmem[3]), 32'h00);
      chk("clear_count", n_clear, 254);
    end

    // Bad headers: zero, above depth, and one that only looks legal when truncated.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      exp_err = 1'b1;
      send_byte(8'(bad_n[t] & 255), 0);
      send_byte(8'((bad_n[t] >> 8) & 255), 0);
      chk("hdr_err_next_cycle", 32'(err_o), 1);
      chk("hdr_err_ready", 32'(byte_ready_o), 0);
      chk("hdr_err_start", 32'(start_o), 0);
      byte_valid = 1'b1;
      repeat (10) begin
        byte_in = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b0;
      chk("err_terminal", 32'(err_o), 1);
      chk("err_no_start", 32'(start_o), 0);
      chk("err_ready_low", 32'(byte_ready_o), 0);
    end

    // Full-depth frame: no clear phase, last word at the top address.
    do_reset();
    for (int i = 0; i < IMEM_DEPTH; i++) f_words[i] = $urandom;
    for (int j = 0; j < DATA_BYTES; j++) f_data[j] = 8'($urandom_range(0, 255));
    build_frame(IMEM_DEPTH, 1'b0);
    run_frame(2, -1);
    finish_frame(1'b1);
    chk("full_no_clear", n_clear, 0);
    chk("full_last_addr", last_imem_addr, 255);
    chk("full_last_word", shadow_imem[255], f_words[255]);

    // Reset after five instruction bytes, then a fresh one-word frame.
    do_reset();
    f_words[0] = $urandom;
    f_words[1] = $urandom;
    build_frame(2, 1'b0);
    run_frame(0, 7);
    chk("partial_word0", shadow_imem[0], f_words[0]);
    do_reset();
    f_words[0] = $urandom;
    build_frame(1, 1'b0);
    run_frame(2, -1);
    finish_frame(1'b1);
    chk("reload_imem0", shadow_imem[0], f_words[0]);
    chk("reload_clear_count", n_clear, 255);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) f_words[i] = $urandom;
      for (int j = 0; j < DATA_BYTES; j++) f_data[j] = 8'($urandom_range(0, 255));
      build_frame(n, 1'b0);
      run_frame($urandom_range(0, 2), -1);
      finish_frame(1'b1);
      chk("rand_clear_count", n_clear, IMEM_DEPTH - n);
    end

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    f_words[0] = 32'hAABBCCDD;
    f_data[0] = 8'h01; f_data[1] = 8'h02; f_data[2] = 8'h03; f_data[3] = 8'h04;
    build_frame(1, 1'b0);
    chk("cksum_model", 32'(cksum_val), 32'h04);
    run_frame(0, -1);
    finish_frame(1'b1);
    do_reset();
    build_frame(1, 1'b1);
    chk("cksum_bad_byte", 32'(frame_q[frame_q.size() - 1]), 32'h05);
    run_frame(1, -1);
    finish_frame(1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream of the CPU: takes a byte stream and loads the program into instruction memory and the input operand into data memory.
- Clears the unused instruction words, then asserts start to release the CPU.
- Replaces the hand-poking of memories and the start pulse that benches do today, and gives silicon/FPGA builds a real load path.
- Sits between a byte source (UART/JTAG bridge) and the CPU's InstrMem/DataMem write ports plus start_i.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words
IMEM_AW, 8, instruction word address width (log2 IMEM_DEPTH)
DMEM_AW, 5, data memory byte address width
DATA_BYTES, 4, payload bytes written to data memory starting at byte address 0

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
byte_i  in  8  stream byte
byte_valid_i  in  1  byte_i valid
byte_ready_o  out  1  loader accepts byte this cycle
imem_we_o  out  1  instruction memory write strobe
imem_addr_o  out  IMEM_AW  instruction word index
imem_data_o  out  32  instruction word
dmem_we_o  out  1  data memory byte write strobe
dmem_addr_o  out  DMEM_AW  data byte address
dmem_data_o  out  8  data byte
start_o  out  1  to CPU start_i; high = run
err_o  out  1  sticky load error

Behaviour:
- Reset (async assert, sync deassert by the integrator): state HDR0; every output 0, including byte_ready_o, start_o and err_o.
- Transfer rule: a byte is accepted when byte_valid_i && byte_ready_o.
  - byte_ready_o is a registered state decode: high in HDR0, HDR1, INSTR, DATA, CKSUM; low otherwise.
  - byte_ready_o does not depend combinationally on byte_valid_i.
- Frame format: N_lo, N_hi (16-bit instruction count, little-endian), then N*4 instruction bytes (each word little-endian), then DATA_BYTES data bytes, then the optional checksum byte.
- HDR0 -> HDR1 on accept.
- HDR1 on accept checks N:
  - N==0 or N>IMEM_DEPTH -> ERROR.
  - Otherwise -> INSTR, with word index and byte lane = 0.
- INSTR: bytes are shifted into a 32-bit assembler (byte k -> bits 8k+7:8k).
  - On the 4th byte: imem_we_o=1 in the next cycle, with imem_addr_o=word index and imem_data_o=assembled word. One-cycle pulse.
  - After word N-1 is accepted -> DATA if N==IMEM_DEPTH, else CLEAR.
- CLEAR: byte_ready_o=0.
  - Writes 0 to word addresses N..IMEM_DEPTH-1, one per cycle, imem_we_o held high.
  - -> DATA after the last address.
- DATA: each accepted byte j produces dmem_we_o=1, dmem_addr_o=j, dmem_data_o=byte in the next cycle.
  - After byte DATA_BYTES-1 -> CKSUM if enabled, else RUN.
- RUN: start_o=1 from the cycle after entry and held until reset. byte_ready_o=0; bytes are ignored.
- ERROR: err_o=1, start_o=0, no writes, byte_ready_o=0. Terminal until reset.
- Write strobes are registered. Address and data hold their last value when the strobe is low.
- A gap in byte_valid_i stalls any state with no timeout and no side effect.
- Reset mid-load: all progress is discarded, start_o drops asynchronously, and the next frame starts at HDR0. Memory contents written before the reset are not undone.
- Word index counter is IMEM_AW+1 bits wide, so the compare against N reaches IMEM_DEPTH without wrap.
- The header count is compared at full 16 bits.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: after DATA the loader enters CKSUM and accepts one byte.
  - Byte equals the XOR of every byte after the header (instructions + data) -> RUN.
  - Mismatch -> ERROR.
  - Header bytes are excluded from the XOR.
- Undefined: no CKSUM state and no accumulator; DATA goes straight to RUN.

Decomposition:
- Package boot_pkg holds:
  - The state enum: HDR0, HDR1, INSTR, CLEAR, DATA, CKSUM, RUN, ERROR.
  - The HDR_BYTES=2 constant.
  - The checksum width.
- One natural sub-module: boot_word_asm, a 4-byte little-endian shift assembler with lane counter and word_done pulse.
- The FSM, counters and strobes stay in boot_loader.

Test Plan:
- Frame N=2, words 0x20080005 and 0x01094020, data 05 00 00 00, continuous valid:
  - imem[0]=0x20080005, imem[1]=0x01094020.
  - imem[2..255]=0 written in 254 consecutive cycles.
  - dmem[0..3]=05,00,00,00.
  - start_o=1 after the last data byte; err_o=0.
- Header N=0, and separately N=257 (bytes 01 01):
  - err_o=1 the cycle after the second header byte.
  - No imem/dmem strobe; start_o stays 0; byte_ready_o=0.
- Same N=2 frame with byte_valid_i toggling 1/0 every cycle plus random 3-cycle gaps:
  - Identical memory image and start_o timing relative to the last accepted byte.
- N=256 full frame:
  - No CLEAR cycles; last write at imem_addr_o=255 with no wrap.
  - start_o=1.
- rst_n_i pulsed low after 5 instruction bytes, then a fresh N=1 frame:
  - start_o=0 during reset; imem[0] receives the new word; reload completes normally.
- BOOT_CHECKSUM_EN defined, N=1 word 0xAABBCCDD, data 01 02 03 04:
  - Checksum 0x04 -> start_o=1.
  - Checksum 0x05 -> err_o=1, start_o=0.
